mem_libo_2p: RTL and testbench

MEM_LIBO_2P -- requirements
Module: mem_libo_2p

---
 rtl/mem_libo_2p_pkg.sv | 38 +++
 rtl/mem_libo_2p_if.sv | 37 +++
 rtl/buf_ram_2p_8xline.sv | 37 +++
 rtl/mem_libo_2p.sv | 199 +++++++++++++++++++
 tb/tb_mem_libo_2p.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_libo_2p_pkg.sv
// ---------------------------------------------------------------------------
// mem_libo_2p_pkg
// Shared definitions for the 32x32 line-in / 4x4 block-out buffer.
//   - FSM state encoding
//   - geometry constants (rows per block fill, 4x4 blocks per fill)
//   - line and block bus widths derived from the pixel width
//   - z-scan index -> (x, y) bit mapping
// ---------------------------------------------------------------------------
package mem_libo_2p_pkg;

    // Encoder-wide pixel width, kept equal to the value in enc_defines.
    localparam int PIXEL_WIDTH = 8;

    localparam int ROW_NUM   = 32;
    localparam int BLK_NUM   = 64;
    localparam int LINE_PIX  = 32;
    localparam int BLK_PIX   = 16;
    localparam int LINE_W    = PIXEL_WIDTH * LINE_PIX;
    localparam int BLK_W     = PIXEL_WIDTH * BLK_PIX;
    // Width of one 4-pixel row slice of a block.
    localparam int ROW_BLK_W = PIXEL_WIDTH * 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Z-scan: even index bits give the column, odd index bits give the row.
    function automatic logic [2:0] zscan_x(input logic [5:0] idx);
        return {idx[4], idx[2], idx[0]};
    endfunction

    function automatic logic [2:0] zscan_y(input logic [5:0] idx);
        return {idx[5], idx[3], idx[1]};
    endfunction

endpackage

// File: rtl/mem_libo_2p_if.sv
// ---------------------------------------------------------------------------
// mem_libo_2p_if
// Bus bundle for mem_libo_2p.
//   Line write side : start_i, wen_i, wrow_i, wdata_i -> wrdy_o
//   Block read side : blk_val_o, blk_x_o, blk_y_o, blk_idx_o, blk_data_o
//                     <- blk_rdy_i, plus the done_o end-of-drain pulse
//   master : the producer/consumer around the buffer
//   slave  : the buffer itself
// ---------------------------------------------------------------------------
interface mem_libo_2p_if;
    import mem_libo_2p_pkg::*;

    logic              start_i;
    logic              wen_i;
    logic [4:0]        wrow_i;
    logic [LINE_W-1:0] wdata_i;
    logic              wrdy_o;

    logic              blk_val_o;
    logic              blk_rdy_i;
    logic [2:0]        blk_x_o;
    logic [2:0]        blk_y_o;
    logic [5:0]        blk_idx_o;
    logic [BLK_W-1:0]  blk_data_o;
    logic              done_o;

    modport master (
        output start_i, wen_i, wrow_i, wdata_i, blk_rdy_i,
        input  wrdy_o, blk_val_o, blk_x_o, blk_y_o, blk_idx_o, blk_data_o, done_o
    );

    modport slave (
        input  start_i, wen_i, wrow_i, wdata_i, blk_rdy_i,
        output wrdy_o, blk_val_o, blk_x_o, blk_y_o, blk_idx_o, blk_data_o, done_o
    );

endinterface

// File: rtl/buf_ram_2p_8xline.sv
// ---------------------------------------------------------------------------
// buf_ram_2p_8xline
// Simple two-port RAM: 8 words of one 32-pixel line each.
//   clk   : clock
//   wen   : write enable, waddr/wdata written on the rising edge
//   ren   : read enable, raddr sampled on the rising edge
//   rdata : read data, valid one cycle after ren (registered)
// No reset: contents and rdata are undefined until written/read.
// ---------------------------------------------------------------------------
module buf_ram_2p_8xline
    import mem_libo_2p_pkg::*;
(
    input  logic              clk,
    input  logic              wen,
    input  logic [2:0]        waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic              ren,
    input  logic [2:0]        raddr,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [8];
    logic [LINE_W-1:0] rdata_q;

    // Write port and registered read port share the clock.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
        if (ren) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_libo_2p.sv
// ---------------------------------------------------------------------------
// mem_libo_2p
// Collects 32 lines of 32 pixels into four line banks, then drains the
// 32x32 block as 64 4x4 blocks in z-scan order.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_libo_2p_if slave port
//              start_i opens a fill, wen_i/wrow_i/wdata_i write one line
//              while wrdy_o; blk_* is a valid/ready block stream and
//              done_o pulses once the last block has been taken.
// Line r lives in bank r[1:0] at address r[4:2], so block row y is a single
// read of all four banks at address y.
// ---------------------------------------------------------------------------
module mem_libo_2p
    import mem_libo_2p_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mem_libo_2p_if.slave bus
);

    state_e            state_q, state_d;
    logic [4:0]        row_cnt_q, row_cnt_d;
    logic              wrdy_q, wrdy_d;
    logic [6:0]        issue_cnt_q, issue_cnt_d;
    logic              rd_vld_q, rd_vld_d;
    logic [5:0]        rd_idx_q, rd_idx_d;
    logic              out_vld_q, out_vld_d;
    logic [5:0]        out_idx_q, out_idx_d;
    logic [BLK_W-1:0]  out_data_q, out_data_d;
    logic              skid_vld_q, skid_vld_d;
    logic [5:0]        skid_idx_q, skid_idx_d;
    logic [BLK_W-1:0]  skid_data_q, skid_data_d;
    logic              done_q, done_d;

    logic              wr_accept;
    logic              pop;
    logic              rd_issue;
    logic [1:0]        credits_used;
    logic [2:0]        rd_addr;
    logic [2:0]        rd_x;
    logic [BLK_W-1:0]  rd_blk;
    logic [LINE_W-1:0] bank_rdata [4];

    // wrdy_q is only ever set in FILL; a start pulse restarts the count, so
    // a line arriving with it is dropped.
    assign wr_accept = wrdy_q & bus.wen_i & ~bus.start_i;
    assign pop       = out_vld_q & bus.blk_rdy_i;

    // Every in-flight read owns a skid entry when it lands; issue only if
    // the entries still free after this cycle's pop cover one more read.
    assign credits_used = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q};
    assign rd_issue     = (state_q == ST_DRAIN) && (issue_cnt_q < 7'(BLK_NUM)) &&
                          ((credits_used < 2'd2) || ((credits_used == 2'd2) && pop));

    assign rd_addr = zscan_y(issue_cnt_q[5:0]);
    assign rd_x    = zscan_x(rd_idx_q);

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_bank
            buf_ram_2p_8xline u_bank (
                .clk   (clk),
                .wen   (wr_accept && (bus.wrow_i[1:0] == 2'(g))),
                .waddr (bus.wrow_i[4:2]),
                .wdata (bus.wdata_i),
                .ren   (rd_issue),
                .raddr (rd_addr),
                .rdata (bank_rdata[g])
            );
        end
    endgenerate

    // Cut pixels 4x..4x+3 out of each bank's line; bank 0 becomes block
    // row 0 in the MSBs.
    always_comb begin
        rd_blk = '0;
        for (int k = 0; k < 4; k++) begin
            rd_blk[(3 - k) * ROW_BLK_W +: ROW_BLK_W] =
                bank_rdata[k][(7 - int'(rd_x)) * ROW_BLK_W +: ROW_BLK_W];
        end
    end

    // Next-state logic for the FSM, fill row counter and drain read counter.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        issue_cnt_d = issue_cnt_q;
        rd_vld_d    = rd_issue;
        rd_idx_d    = rd_issue ? issue_cnt_q[5:0] : rd_idx_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d   = ST_FILL;
                    row_cnt_d = '0;
                end
            end
            ST_FILL: begin
                if (bus.start_i) begin
                    row_cnt_d = '0;
                end else if (wr_accept) begin
                    row_cnt_d = row_cnt_q + 5'd1;
                    if (row_cnt_q == 5'(ROW_NUM - 1)) begin
                        state_d     = ST_DRAIN;
                        issue_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (rd_issue) begin
                    issue_cnt_d = issue_cnt_q + 7'd1;
                end
                if (pop && (out_idx_q == 6'(BLK_NUM - 1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        wrdy_d = (state_d == ST_FILL);
    end

    // Two-entry skid buffer: out_* drives the port, skid_* catches a read
    // that lands while the port is stalled.
    always_comb begin
        out_vld_d   = out_vld_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        skid_vld_d  = skid_vld_q;
        skid_idx_d  = skid_idx_q;
        skid_data_d = skid_data_q;
        if (!out_vld_q || pop) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_idx_d  = skid_idx_q;
                out_data_d = skid_data_q;
                skid_vld_d = rd_vld_q;
                if (rd_vld_q) begin
                    skid_idx_d  = rd_idx_q;
                    skid_data_d = rd_blk;
                end
            end else if (rd_vld_q) begin
                out_vld_d  = 1'b1;
                out_idx_d  = rd_idx_q;
                out_data_d = rd_blk;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (rd_vld_q) begin
            skid_vld_d  = 1'b1;
            skid_idx_d  = rd_idx_q;
            skid_data_d = rd_blk;
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_cnt_q   <= '0;
            wrdy_q      <= 1'b0;
            issue_cnt_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            out_vld_q   <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_idx_q  <= '0;
            skid_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            wrdy_q      <= wrdy_d;
            issue_cnt_q <= issue_cnt_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            out_vld_q   <= out_vld_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_idx_q  <= skid_idx_d;
            skid_data_q <= skid_data_d;
            done_q      <= done_d;
        end
    end

    assign bus.wrdy_o     = wrdy_q;
    assign bus.blk_val_o  = out_vld_q;
    assign bus.blk_idx_o  = out_idx_q;
    assign bus.blk_x_o    = zscan_x(out_idx_q);
    assign bus.blk_y_o    = zscan_y(out_idx_q);
    assign bus.blk_data_o = out_data_q;
    assign bus.done_o     = done_q;

endmodule

// File: tb/tb_mem_libo_2p.sv
// ---------------------------------------------------------------------------
// tb_mem_libo_2p
// Directed bench for mem_libo_2p: fills of a known pixel ramp, drained with
// and without backpressure, plus restart, abort and stray-write sequences.
// ---------------------------------------------------------------------------
module tb_mem_libo_2p;
    import mem_libo_2p_pkg::*;

    typedef struct {
        bit reverse;
        bit rdy_toggle;
        bit stray;
        int exp_first;
        int exp_span;
    } scen_t;

    typedef struct {
        int          idx;
        logic [2:0]  x;
        logic [2:0]  y;
        logic [31:0] row0;
        logic [31:0] row3;
    } spot_t;

    logic clk;
    logic rst;

    mem_libo_2p_if bus();

    mem_libo_2p dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks;
    int n_pass;

    logic [BLK_W-1:0] cap_data [BLK_NUM];
    logic [2:0]       cap_x    [BLK_NUM];
    logic [2:0]       cap_y    [BLK_NUM];

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pixel value of row r, column c: ramp or constant 0xAA.
    function automatic logic [7:0] pix(input int r, input int c, input int mode);
        if (mode == 1) return 8'hAA;
        return 8'((r * 32 + c) % 256);
    endfunction

    function automatic logic [LINE_W-1:0] make_line(input int r, input int mode);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int c = 0; c < 32; c++) begin
            l[LINE_W - 1 - 8 * c -: 8] = pix(r, c, mode);
        end
        return l;
    endfunction

    function automatic logic [BLK_W-1:0] exp_blk(input int idx, input int mode);
        logic [5:0]       b;
        logic [2:0]       x;
        logic [2:0]       y;
        logic [BLK_W-1:0] r;
        b = 6'(idx);
        x = {b[4], b[2], b[0]};
        y = {b[5], b[3], b[1]};
        r = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                r[BLK_W - 1 - 8 * (4 * k + j) -: 8] = pix(4 * int'(y) + k, 4 * int'(x) + j, mode);
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of write-side inputs at the falling edge.
    task automatic applyStimulus(input logic start, input logic wen,
                                 input logic [4:0] row, input logic [LINE_W-1:0] data);
        @(negedge clk);
        bus.start_i = start;
        bus.wen_i   = wen;
        bus.wrow_i  = row;
        bus.wdata_i = data;
    endtask

    task automatic run_fill(input bit reverse, input int mode);
        int r;
        applyStimulus(1'b1, 1'b0, 5'd0, '0);
        for (int i = 0; i < ROW_NUM; i++) begin
            r = reverse ? (ROW_NUM - 1 - i) : i;
            applyStimulus(1'b0, 1'b1, 5'(r), make_line(r, mode));
            if (i == 0) checkOutput("wrdy_in_fill", 192'(bus.wrdy_o), 192'(1));
        end
    endtask

    // Drain all 64 blocks; the first loop cycle is the DRAIN entry cycle.
    task automatic run_drain(input bit rdy_toggle, input bit stray, input int mode,
                             input int exp_first, input int exp_span);
        int               got;
        int               cyc;
        int               first_val;
        int               first_acc;
        int               last_acc;
        bit               stalled;
        bit               rdy;
        logic [5:0]       b;
        logic [5:0]       held_idx;
        logic [BLK_W-1:0] held_data;
        got = 0; cyc = 0; first_val = -1; first_acc = -1; last_acc = -1;
        stalled = 1'b0; held_idx = '0; held_data = '0;
        while (got < BLK_NUM && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.start_i   = (cyc == 5);
            bus.wen_i     = stray;
            bus.wrow_i    = 5'(cyc);
            bus.wdata_i   = '1;
            rdy           = rdy_toggle ? (cyc % 2 == 0) : 1'b1;
            bus.blk_rdy_i = rdy;
            if (bus.blk_val_o) begin
                if (first_val < 0) first_val = cyc;
                if (stalled) begin
                    checkOutput("stall_hold", 192'({bus.blk_idx_o, bus.blk_data_o}),
                                192'({held_idx, held_data}));
                end
                if (rdy) begin
                    b = 6'(got);
                    checkOutput("blk_idx", 192'(bus.blk_idx_o), 192'(b));
                    checkOutput("blk_xy", 192'({bus.blk_x_o, bus.blk_y_o}),
                                192'({b[4], b[2], b[0], b[5], b[3], b[1]}));
                    checkOutput("blk_data", 192'(bus.blk_data_o), 192'(exp_blk(got, mode)));
                    cap_data[got] = bus.blk_data_o;
                    cap_x[got]    = bus.blk_x_o;
                    cap_y[got]    = bus.blk_y_o;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_idx  = bus.blk_idx_o;
                    held_data = bus.blk_data_o;
                end
            end
        end
        checkOutput("blk_count", 192'(got), 192'(BLK_NUM));
        checkOutput("first_valid_cycle", 192'(first_val), 192'(exp_first));
        checkOutput("drain_span", 192'(last_acc - first_acc), 192'(exp_span));
        @(negedge clk);
        bus.start_i = 1'b0; bus.wen_i = 1'b0; bus.blk_rdy_i = 1'b0;
        checkOutput("done_pulse", 192'(bus.done_o), 192'(1));
        checkOutput("idle_after_done", 192'({bus.wrdy_o, bus.blk_val_o}), 192'(0));
        @(negedge clk);
        checkOutput("done_single", 192'(bus.done_o), 192'(0));
    endtask

    task automatic check_spots(input spot_t spots [8]);
        for (int i = 0; i < 8; i++) begin
            checkOutput("spot_xy", 192'({cap_x[spots[i].idx], cap_y[spots[i].idx]}),
                        192'({spots[i].x, spots[i].y}));
            checkOutput("spot_rows", 192'({cap_data[spots[i].idx][BLK_W-1 -: 32], cap_data[spots[i].idx][31:0]}),
                        192'({spots[i].row0, spots[i].row3}));
        end
    endtask

    // Restart after 10 lines, then a constant fill; the line sent with the
    // restarting start_i must be dropped.
    task automatic restart_seq();
        applyStimulus(1'b1, 1'b0, 5'd0, '0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(i), make_line(i, 0));
        end
        applyStimulus(1'b1, 1'b1, 5'd31, make_line(31, 0));
        for (int i = 0; i < ROW_NUM; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(i), make_line(i, 1));
        end
        run_drain(1'b0, 1'b0, 1, 3, 63);
    endtask

    // Reset in the middle of a drain, when block 20 is on the port.
    task automatic abort_seq();
        int cyc;
        bit hit;
        cyc = 0; hit = 1'b0;
        run_fill(1'b0, 0);
        while (!hit && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.wen_i     = 1'b0;
            bus.blk_rdy_i = 1'b1;
            if (bus.blk_val_o && bus.blk_idx_o == 6'd20) begin
                rst = 1'b1;
                hit = 1'b1;
            end
        end
        checkOutput("reach_idx20", 192'(hit), 192'(1));
        @(negedge clk);
        checkOutput("abort_val_wrdy_done", 192'({bus.blk_val_o, bus.wrdy_o, bus.done_o}), 192'(0));
        checkOutput("abort_outputs", 192'({bus.blk_idx_o, bus.blk_x_o, bus.blk_y_o, bus.blk_data_o}), 192'(0));
        rst = 1'b0;
        bus.blk_rdy_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("no_done_after_abort", 192'({bus.done_o, bus.blk_val_o, bus.wrdy_o}), 192'(0));
        end
    endtask

    initial begin
        scen_t scen  [4];
        spot_t spots [8];

        n_checks = 0;
        n_pass   = 0;

        // reverse, rdy_toggle, stray, first valid cycle, accept span
        scen[0] = '{1'b0, 1'b0, 1'b0, 3, 63};
        scen[1] = '{1'b0, 1'b1, 1'b0, 3, 126};
        scen[2] = '{1'b1, 1'b0, 1'b0, 3, 63};
        scen[3] = '{1'b0, 1'b0, 1'b1, 3, 63};

        // idx, x, y, block row 0, block row 3 for the ramp fill
        spots[0] = '{0,  3'd0, 3'd0, 32'h00010203, 32'h60616263};
        spots[1] = '{1,  3'd1, 3'd0, 32'h04050607, 32'h64656667};
        spots[2] = '{2,  3'd0, 3'd1, 32'h80818283, 32'hE0E1E2E3};
        spots[3] = '{3,  3'd1, 3'd1, 32'h84858687, 32'hE4E5E6E7};
        spots[4] = '{5,  3'd3, 3'd0, 32'h0C0D0E0F, 32'h6C6D6E6F};
        spots[5] = '{20, 3'd6, 3'd0, 32'h18191A1B, 32'h78797A7B};
        spots[6] = '{42, 3'd0, 3'd7, 32'h80818283, 32'hE0E1E2E3};
        spots[7] = '{63, 3'd7, 3'd7, 32'h9C9D9E9F, 32'hFCFDFEFF};

        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.wen_i     = 1'b0;
        bus.wrow_i    = '0;
        bus.wdata_i   = '0;
        bus.blk_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_flags", 192'({bus.wrdy_o, bus.blk_val_o, bus.done_o}), 192'(0));
        checkOutput("reset_outputs", 192'({bus.blk_idx_o, bus.blk_x_o, bus.blk_y_o, bus.blk_data_o}), 192'(0));
        rst = 1'b0;

        for (int s = 0; s < 4; s++) begin
            if (scen[s].stray) begin
                for (int i = 0; i < 3; i++) begin
                    applyStimulus(1'b0, 1'b1, 5'(i), '1);
                    checkOutput("wrdy_idle", 192'(bus.wrdy_o), 192'(0));
                end
            end
            run_fill(scen[s].reverse, 0);
            run_drain(scen[s].rdy_toggle, scen[s].stray, 0, scen[s].exp_first, scen[s].exp_span);
            check_spots(spots);
        end

        restart_seq();
        abort_seq();

        run_fill(1'b0, 0);
        run_drain(1'b0, 1'b0, 0, 3, 63);
        check_spots(spots);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
